// File: rtl/ctrl_pipe_if.sv
// rtl/ctrl_pipe_if.sv - decode/hazard-unit to control-pipe bundle
interface ctrl_pipe_if #(
    parameter int CTRL_W = 32,
    parameter int STAGES = 3
);
    localparam int OCC_W = $clog2(STAGES + 1);

    logic [CTRL_W-1:0]        ctrl_i;
    logic                     valid_i;
    logic                     ready_o;
    logic [STAGES-1:0]        stall_i;
    logic [STAGES-1:0]        flush_i;
    logic [STAGES*CTRL_W-1:0] stage_ctrl_o;
    logic [STAGES-1:0]        stage_valid_o;
    logic [OCC_W-1:0]         occupancy_o;
    logic                     retire_o;
    logic [31:0]              retire_count_o;

    // Decode and hazard unit side
    modport master (
        output ctrl_i, valid_i, stall_i, flush_i,
        input  ready_o, stage_ctrl_o, stage_valid_o, occupancy_o, retire_o, retire_count_o
    );

    // Pipeline side
    modport slave (
        input  ctrl_i, valid_i, stall_i, flush_i,
        output ready_o, stage_ctrl_o, stage_valid_o, occupancy_o, retire_o, retire_count_o
    );
endinterface

// File: rtl/ctrl_pipe.sv
// rtl/ctrl_pipe.sv - control-word pipeline with per-stage valid, stall, flush and retire counting
module ctrl_pipe #(
    parameter int               CTRL_W   = 32,
    parameter int               STAGES   = 3,
    parameter logic [CTRL_W-1:0] NOP_CTRL = '0
) (
    input  logic       clk,
    input  logic       reset,
    ctrl_pipe_if.slave bus
);
    localparam int OCC_W = $clog2(STAGES + 1);

    logic [STAGES-1:0] hold;
    logic [STAGES-1:0] bubble_in;
    logic [STAGES-1:0] src_valid;
    logic [STAGES-1:0] valid_q;
    logic [CTRL_W-1:0] src_ctrl [STAGES];
    logic [CTRL_W-1:0] ctrl_q   [STAGES];
    logic              retire;
    logic [31:0]       retire_count;
    logic [OCC_W-1:0]  occupancy;

    // A stall at stage k or anywhere downstream of it freezes stage k
    always_comb begin
        hold = '0;
        for (int k = 0; k < STAGES; k++) begin
            hold[k] = |(bus.stall_i >> k);
        end
    end

    // Stage k takes a bubble when its upstream neighbour is frozen but it is not
    assign bubble_in = {hold[STAGES-2:0], 1'b0};

    // Next word for each stage: decode feeds stage 0, the previous stage feeds the rest
    always_comb begin
        src_valid   = {valid_q[STAGES-2:0], bus.valid_i};
        src_ctrl[0] = bus.valid_i ? bus.ctrl_i : NOP_CTRL;
        for (int k = 1; k < STAGES; k++) begin
            src_ctrl[k] = ctrl_q[k-1];
        end
    end

    // Stage registers; priority is flush, then hold, then bubble, then advance
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                ctrl_q[k] <= NOP_CTRL;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (bus.flush_i[k]) begin
                    valid_q[k] <= 1'b0;
                    ctrl_q[k]  <= NOP_CTRL;
                end else if (!hold[k]) begin
                    if (bubble_in[k]) begin
                        valid_q[k] <= 1'b0;
                        ctrl_q[k]  <= NOP_CTRL;
                    end else begin
                        valid_q[k] <= src_valid[k];
                        ctrl_q[k]  <= src_ctrl[k];
                    end
                end
            end
        end
    end

    // A real instruction leaves the last stage only if that stage is neither held nor killed
    assign retire = valid_q[STAGES-1] & ~bus.stall_i[STAGES-1] & ~bus.flush_i[STAGES-1];

    // Free-running retire counter, wraps naturally at 32 bits
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retire_count <= '0;
        end else if (retire) begin
            retire_count <= retire_count + 32'd1;
        end
    end

    // Population count of the valid bits
    always_comb begin
        occupancy = '0;
        for (int k = 0; k < STAGES; k++) begin
            occupancy = occupancy + OCC_W'(valid_q[k]);
        end
    end

    // Pack per-stage control words onto the flat output bus
    always_comb begin
        bus.stage_ctrl_o = '0;
        for (int k = 0; k < STAGES; k++) begin
            bus.stage_ctrl_o[k*CTRL_W +: CTRL_W] = ctrl_q[k];
        end
    end

    assign bus.ready_o        = ~hold[0];
    assign bus.stage_valid_o  = valid_q;
    assign bus.occupancy_o    = occupancy;
    assign bus.retire_o       = retire;
    assign bus.retire_count_o = retire_count;
endmodule

// File: tb/tb_ctrl_pipe.sv
// tb/tb_ctrl_pipe.sv - scoreboard bench for ctrl_pipe against a stage-list reference model
module tb_ctrl_pipe;
    localparam int W = 8;
    localparam int S = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ctrl_pipe_if #(.CTRL_W(W), .STAGES(S)) bus ();

    ctrl_pipe #(.CTRL_W(W), .STAGES(S), .NOP_CTRL(8'h00)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: the list of slots, oldest at index S-1
    bit         mv [S];
    logic [7:0] mc [S];
    logic [31:0] mcount;
    logic [7:0] exp_q [$];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endfunction

    function automatic logic [7:0] sctrl(int k);
        logic [S*W-1:0] v;
        v = bus.stage_ctrl_o;
        return v[k*W +: W];
    endfunction

    function automatic void m_reset();
        for (int k = 0; k < S; k++) begin
            mv[k] = 1'b0;
            mc[k] = 8'h00;
        end
        mcount = 32'd0;
        exp_q.delete();
    endfunction

    function automatic bit m_retire();
        return mv[S-1] && !bus.stall_i[S-1] && !bus.flush_i[S-1];
    endfunction

    // One clock edge of the pipe, from the rules for each slot
    function automatic void m_edge(logic [S-1:0] st, logic [S-1:0] fl, bit vi, logic [7:0] ci);
        bit         nv [S];
        logic [7:0] nc [S];
        for (int k = 0; k < S; k++) begin
            bit frozen;
            frozen = (st >> k) != 0;
            if (fl[k]) begin
                nv[k] = 1'b0; nc[k] = 8'h00;
            end else if (frozen) begin
                nv[k] = mv[k]; nc[k] = mc[k];
            end else if (k > 0 && ((st >> (k - 1)) != 0)) begin
                nv[k] = 1'b0; nc[k] = 8'h00;
            end else if (k == 0) begin
                nv[k] = vi; nc[k] = vi ? ci : 8'h00;
            end else begin
                nv[k] = mv[k-1]; nc[k] = mc[k-1];
            end
        end
        for (int k = 0; k < S; k++) begin
            mv[k] = nv[k];
            mc[k] = nc[k];
        end
    endfunction

    task automatic check_state();
        int occ;
        occ = 0;
        for (int k = 0; k < S; k++) begin
            chk($sformatf("stage_valid[%0d]", k), 32'(bus.stage_valid_o[k]), 32'(mv[k]));
            chk($sformatf("stage_ctrl[%0d]", k), 32'(sctrl(k)), 32'(mc[k]));
            occ += int'(mv[k]);
        end
        chk("occupancy", 32'(bus.occupancy_o), 32'(occ));
        chk("retire_count", bus.retire_count_o, mcount);
        chk("ready", 32'(bus.ready_o), 32'(bus.stall_i == '0));
    endtask

    // Issue one cycle: predict the retirement, take the edge, advance the model, check
    task automatic tick();
        bit          r;
        logic [S-1:0] st, fl;
        bit          vi;
        logic [7:0]  ci;
        r  = m_retire();
        st = bus.stall_i;
        fl = bus.flush_i;
        vi = bus.valid_i;
        ci = bus.ctrl_i;
        if (r) exp_q.push_back(mc[S-1]);
        @(posedge clk);
        m_edge(st, fl, vi, ci);
        if (r) mcount = mcount + 32'd1;
        #1;
        check_state();
    endtask

    task automatic feed(logic [7:0] w);
        bus.valid_i = 1'b1;
        bus.ctrl_i  = w;
        tick();
    endtask

    // Monitor: every retirement the DUT presents must match the next expected word
    always @(negedge clk) begin
        if (!reset && bus.retire_o) begin
            if (exp_q.size() == 0) begin
                chk("retire_unexpected", 32'(1), 32'(0));
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                chk("retire_word", 32'(sctrl(S-1)), 32'(e));
            end
        end
    end

    initial begin
        reset       = 1'b1;
        bus.ctrl_i  = '0;
        bus.valid_i = 1'b0;
        bus.stall_i = '0;
        bus.flush_i = '0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(bus.stage_valid_o), 32'(0));
        chk("rst_ctrl", 32'(bus.stage_ctrl_o), 32'(0));
        chk("rst_count", bus.retire_count_o, 32'd0);
        chk("rst_occ", 32'(bus.occupancy_o), 32'(0));
        chk("rst_retire", 32'(bus.retire_o), 32'(0));
        chk("rst_ready", 32'(bus.ready_o), 32'(1));
        reset = 1'b0;

        // Streaming
        feed(8'h11);
        feed(8'h22);
        feed(8'h33);
        chk("stream_s2", 32'(sctrl(2)), 32'h11);
        feed(8'h44);
        bus.valid_i = 1'b0;
        repeat (3) tick();
        chk("stream_count", bus.retire_count_o, 32'd4);

        // Stall on stage 1
        feed(8'hC3);
        feed(8'hB2);
        feed(8'hA1);
        bus.ctrl_i  = 8'hD4;
        bus.stall_i = 3'b010;
        #1;
        chk("stall_ready", 32'(bus.ready_o), 32'(0));
        chk("stall_s2_pre", 32'(sctrl(2)), 32'hC3);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("stall_s0", 32'(sctrl(0)), 32'hA1);
            chk("stall_s1", 32'(sctrl(1)), 32'hB2);
            chk("stall_s2_bubble", {23'd0, bus.stage_valid_o[2], sctrl(2)}, 32'h0);
        end
        bus.stall_i = '0;
        tick();
        chk("stall_release_s2", 32'(sctrl(2)), 32'hB2);
        chk("stall_release_s0", 32'(sctrl(0)), 32'hD4);
        bus.valid_i = 1'b0;
        repeat (3) tick();

        // Flush of stages 0 and 1 while decode offers a word
        feed(8'hA5);
        feed(8'hC6);
        feed(8'hB7);
        bus.ctrl_i  = 8'hD8;
        bus.flush_i = 3'b011;
        tick();
        chk("flush_valid", 32'(bus.stage_valid_o), 32'b100);
        chk("flush_s0", 32'(sctrl(0)), 32'h00);
        chk("flush_s1", 32'(sctrl(1)), 32'h00);
        chk("flush_s2", 32'(sctrl(2)), 32'hC6);
        bus.flush_i = '0;
        bus.valid_i = 1'b0;
        #1;
        chk("flush_retire", 32'(bus.retire_o), 32'(1));
        repeat (2) tick();

        // Stall and flush on the last stage together
        feed(8'hE1);
        feed(8'hE2);
        feed(8'hE3);
        bus.ctrl_i  = 8'hF0;
        bus.stall_i = 3'b100;
        bus.flush_i = 3'b100;
        #1;
        chk("sf_retire", 32'(bus.retire_o), 32'(0));
        begin
            logic [31:0] c0;
            c0 = bus.retire_count_o;
            tick();
            chk("sf_count", bus.retire_count_o, c0);
        end
        chk("sf_s2", {23'd0, bus.stage_valid_o[2], sctrl(2)}, 32'h0);
        chk("sf_s1", 32'(sctrl(1)), 32'hE2);
        chk("sf_s0", 32'(sctrl(0)), 32'hE3);
        bus.stall_i = '0;
        bus.flush_i = '0;
        bus.valid_i = 1'b0;
        repeat (3) tick();

        // Counter wrap
        force dut.retire_count = 32'hFFFF_FFFE;
        #1;
        release dut.retire_count;
        mcount = 32'hFFFF_FFFE;
        chk("wrap_forced", bus.retire_count_o, 32'hFFFF_FFFE);
        feed(8'h5A);
        feed(8'h6B);
        feed(8'h7C);
        bus.valid_i = 1'b0;
        tick();
        chk("wrap_1", bus.retire_count_o, 32'hFFFF_FFFF);
        tick();
        chk("wrap_2", bus.retire_count_o, 32'h0000_0000);
        tick();
        chk("wrap_3", bus.retire_count_o, 32'h0000_0001);

        // Asynchronous reset with every stage valid
        feed(8'h91);
        feed(8'h92);
        feed(8'h93);
        chk("pre_reset_full", 32'(bus.stage_valid_o), 32'b111);
        reset = 1'b1;
        #1;
        chk("areset_valid", 32'(bus.stage_valid_o), 32'(0));
        chk("areset_ctrl", 32'(bus.stage_ctrl_o), 32'(0));
        chk("areset_count", bus.retire_count_o, 32'd0);
        chk("areset_occ", 32'(bus.occupancy_o), 32'(0));
        m_reset();
        bus.valid_i = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_state();

        // Randomized traffic; decode keeps its word until it is taken
        for (int i = 0; i < 400; i++) begin
            if (bus.stall_i == '0) begin
                bus.valid_i = 1'($urandom_range(0, 1));
                bus.ctrl_i  = 8'($urandom);
            end
            bus.stall_i = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
            bus.flush_i = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'b000;
            tick();
        end

        bus.stall_i = '0;
        bus.flush_i = '0;
        bus.valid_i = 1'b0;
        repeat (4) tick();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
